// File: rtl/pc_gen_if.sv
// Fetch-PC generator bundle: pipeline control in, fetch PC and RAS/redirect status out.
// The master drives the controls and the slave (pc_gen) drives the PC and status.
interface pc_gen_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned N_STALL = 2
);

  logic               start_i;
  logic [N_STALL-1:0] stall_i;
  logic               hazard_i;
  logic               exc_i;
  logic               br_taken_i;
  logic [PC_W-1:0]    br_target_i;
  logic               call_i;
  logic               ret_i;

  logic [PC_W-1:0]    pc_o;
  logic [PC_W-1:0]    pc_next_o;
  logic               ras_empty_o;
  logic               redir_pend_o;

  modport master (
    output start_i, stall_i, hazard_i, exc_i, br_taken_i, br_target_i, call_i, ret_i,
    input  pc_o, pc_next_o, ras_empty_o, redir_pend_o
  );

  modport slave (
    input  start_i, stall_i, hazard_i, exc_i, br_taken_i, br_target_i, call_i, ret_i,
    output pc_o, pc_next_o, ras_empty_o, redir_pend_o
  );

endinterface

// File: rtl/pc_gen.sv
// Fetch-PC generator: stall/hazard holds, exception/branch redirects with a pending latch
// for redirects seen during a stall, and a circular return-address stack for call/return.
module pc_gen #(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_VEC  = '0,
  parameter logic [PC_W-1:0] EXC_VEC    = PC_W'(32'h80),
  parameter int unsigned     INST_BYTES = 4,
  parameter int unsigned     N_STALL    = 2,
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  pc_gen_if.slave   bus
);

  localparam int unsigned     PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned     CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [PC_W-1:0] INC     = PC_W'(INST_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_BR,
    PEND_EXC
  } pend_e;

  pend_e             pend_q, pend_d;
  logic [PC_W-1:0]   pend_tgt_q, pend_tgt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ras_we;
  logic [PTR_W-1:0]  ras_widx;
  logic [PC_W-1:0]   ras_wdata;

  logic [N_STALL-1:0] stall_w;
  logic               stalled;
  logic [PC_W-1:0]    seq_pc;
  logic [PTR_W-1:0]   top_idx;
  logic [PC_W-1:0]    ras_top;

  assign stall_w = bus.stall_i;
  assign stalled = |stall_w;
  assign seq_pc  = pc_q + INC;
  assign top_idx = ptr_q - PTR_W'(1);
  assign ras_top = ras_q[top_idx];

  // State registers: PC, pending redirect, RAS pointer/count
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q       <= RESET_VEC;
      pend_q     <= PEND_NONE;
      pend_tgt_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // RAS storage; contents are meaningless once cnt_q says empty
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else if (ras_we) begin
      ras_q[ras_widx] <= ras_wdata;
    end
  end

  // Next-state selection in strict priority order
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ras_we     = 1'b0;
    ras_widx   = ptr_q;
    ras_wdata  = seq_pc;

    if (stalled) begin
      // An exception outranks, and may overwrite, a pending branch but never the reverse
      if (bus.exc_i) begin
        pend_d     = PEND_EXC;
        pend_tgt_d = EXC_VEC;
      end else if (bus.br_taken_i && (pend_q != PEND_EXC)) begin
        pend_d     = PEND_BR;
        pend_tgt_d = bus.br_target_i;
      end
    end else if (!bus.start_i) begin
      pc_d   = RESET_VEC;
      pend_d = PEND_NONE;
      ptr_d  = '0;
      cnt_d  = '0;
    end else if (bus.exc_i) begin
      pc_d   = EXC_VEC;
      pend_d = PEND_NONE;
      ptr_d  = '0;
      cnt_d  = '0;
    end else if (pend_q != PEND_NONE) begin
      pc_d   = pend_tgt_q;
      pend_d = PEND_NONE;
    end else if (bus.br_taken_i) begin
      pc_d = bus.br_target_i;
    end else if (bus.hazard_i) begin
      pc_d = pc_q;
    end else if (bus.ret_i && (cnt_q != '0)) begin
      pc_d = ras_top;
      // Call+return reuses the popped slot, so depth is unchanged
      if (bus.call_i) begin
        ras_we   = 1'b1;
        ras_widx = top_idx;
      end else begin
        ptr_d = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      pc_d = seq_pc;
      if (bus.call_i) begin
        ras_we = 1'b1;
        ptr_d  = ptr_q + PTR_W'(1);
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.pc_next_o    = pc_d;
  assign bus.ras_empty_o  = (cnt_q == '0);
  assign bus.redir_pend_o = (pend_q != PEND_NONE);

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: expected PC/status pushed per driven cycle,
// popped and compared after the edge.
module tb_pc_gen;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        empty;
    logic        pend;
  } exp_t;

  exp_t exp_q[$];

  pc_gen_if #(.PC_W(32), .N_STALL(2)) bus ();

  pc_gen #(
    .PC_W      (32),
    .RESET_VEC (32'h0),
    .EXC_VEC   (32'h80),
    .INST_BYTES(4),
    .N_STALL   (2),
    .RAS_DEPTH (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of controls, check pc_next_o before the edge and state after it
  task automatic step(input logic st, input logic [1:0] stl, input logic hz, input logic ex,
                      input logic br, input logic [31:0] tgt, input logic cl, input logic rt,
                      input logic [31:0] e_pc, input logic e_emp, input logic e_pend);
    exp_t e;
    bus.start_i     = st;
    bus.stall_i     = stl;
    bus.hazard_i    = hz;
    bus.exc_i       = ex;
    bus.br_taken_i  = br;
    bus.br_target_i = tgt;
    bus.call_i      = cl;
    bus.ret_i       = rt;
    exp_q.push_back('{pc: e_pc, empty: e_emp, pend: e_pend});
    #1;
    check("pc_next", bus.pc_next_o, e_pc);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pc", bus.pc_o, e.pc);
    check("ras_empty", 32'(bus.ras_empty_o), 32'(e.empty));
    check("redir_pend", 32'(bus.redir_pend_o), 32'(e.pend));
  endtask

  initial begin
    rst             = 1'b0;
    bus.start_i     = 1'b0;
    bus.stall_i     = '0;
    bus.hazard_i    = 1'b0;
    bus.exc_i       = 1'b0;
    bus.br_taken_i  = 1'b0;
    bus.br_target_i = '0;
    bus.call_i      = 1'b0;
    bus.ret_i       = 1'b0;
    #3;
    check("rst_pc", bus.pc_o, 32'h0);
    check("rst_empty", 32'(bus.ras_empty_o), 32'd1);
    check("rst_pend", 32'(bus.redir_pend_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: sequential fetch
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 0, 32'h4,  1, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 0, 32'h8,  1, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 0, 32'hC,  1, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 0, 32'h10, 1, 0);

    // T2: branch latched during a stall
    step(1, 2'b01, 0, 0, 1, 32'h200, 0, 0, 32'h10, 1, 1);
    step(1, 2'b01, 0, 0, 0, 32'h0,   0, 0, 32'h10, 1, 1);
    step(1, 2'b10, 0, 0, 0, 32'h0,   1, 1, 32'h10, 1, 1);
    step(1, 2'b00, 0, 0, 0, 32'h0,   0, 0, 32'h200, 1, 0);

    // T3: exception overrides pending branch, later branch ignored
    step(1, 2'b01, 0, 0, 1, 32'h200, 0, 0, 32'h200, 1, 1);
    step(1, 2'b01, 0, 1, 0, 32'h0,   0, 0, 32'h200, 1, 1);
    step(1, 2'b01, 0, 0, 1, 32'h300, 0, 0, 32'h200, 1, 1);
    step(1, 2'b00, 0, 0, 0, 32'h0,   0, 0, 32'h80,  1, 0);

    // T4: two calls, two returns, return on empty RAS
    step(1, 2'b00, 0, 0, 1, 32'h10, 0, 0, 32'h10, 1, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0,  1, 0, 32'h14, 0, 0);
    step(1, 2'b00, 0, 0, 1, 32'h40, 1, 0, 32'h40, 0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0,  1, 0, 32'h44, 0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0,  0, 1, 32'h44, 0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0,  0, 1, 32'h14, 1, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0,  0, 1, 32'h18, 1, 0);

    // T5: start_i low resets, then overflow the 4-deep RAS
    step(0, 2'b00, 0, 0, 0, 32'h0, 1, 0, 32'h0,  1, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 1, 0, 32'h4,  0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 1, 0, 32'h8,  0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 1, 0, 32'hC,  0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 1, 0, 32'h10, 0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 1, 0, 32'h14, 0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 1, 32'h14, 0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 1, 32'h10, 0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 1, 32'hC,  0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 1, 32'h8,  1, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 1, 32'hC,  1, 0);

    // Simultaneous call+return replaces the top entry
    step(1, 2'b00, 0, 0, 0, 32'h0, 1, 0, 32'h10, 0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 1, 1, 32'h10, 0, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 1, 32'h14, 1, 0);

    // Hazard holds and blocks call; pending redirect beats hazard
    step(1, 2'b00, 1, 0, 0, 32'h0,   1, 0, 32'h14,  1, 0);
    step(1, 2'b01, 0, 0, 1, 32'h100, 0, 0, 32'h14,  1, 1);
    step(1, 2'b00, 1, 0, 0, 32'h0,   0, 0, 32'h100, 1, 0);

    // T6: exception wins over branch and hazard, empties RAS
    step(1, 2'b00, 0, 0, 0, 32'h0,   1, 0, 32'h104, 0, 0);
    step(1, 2'b00, 1, 1, 1, 32'h300, 0, 0, 32'h80,  1, 0);

    // Stall outranks start_i low; then start_i low returns to reset vector
    step(0, 2'b01, 0, 0, 0, 32'h0, 0, 0, 32'h80, 1, 0);
    step(0, 2'b00, 0, 0, 0, 32'h0, 0, 0, 32'h0,  1, 0);

    // PC wraps modulo 2^32
    step(1, 2'b00, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0);

    // Async reset mid-stall discards pending redirect and RAS
    step(1, 2'b00, 0, 0, 0, 32'h0,   1, 0, 32'h4, 0, 0);
    step(1, 2'b01, 0, 0, 1, 32'h300, 0, 0, 32'h4, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_pc", bus.pc_o, 32'h0);
    check("mid_rst_empty", 32'(bus.ras_empty_o), 32'd1);
    check("mid_rst_pend", 32'(bus.redir_pend_o), 32'd0);
    rst = 1'b1;
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 1, 32'h4, 1, 0);
    step(1, 2'b00, 0, 0, 0, 32'h0, 0, 0, 32'h8, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
